// File: rtl/fp_pkg.sv
// Shared FP32 definitions for the FP datapath (divider and multiplier).
package fp_pkg;
    localparam int          EXP_W   = 8;
    localparam int          MAN_W   = 23;
    localparam int          BIAS    = 127;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } fsm_state_e;
endpackage

// File: rtl/mantissa_div.sv
// Iterative restoring divider for 24-bit significands.
// Produces 25 quotient bits (MSB first), one per cycle after start.
module mantissa_div
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [MAN_W-1:0] man_a,
    input  logic [MAN_W-1:0] man_b,
    output logic             busy,
    output logic             done,   // final quotient bit is being produced this cycle
    output logic [24:0]      quo
);
    logic [25:0] rem_q, rem_d;
    logic [23:0] dvs_q, dvs_d;
    logic [24:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic [25:0] diff;

    assign busy = run_q;
    assign done = run_q && (cnt_q == 5'd24);
    assign quo  = quo_q;

    // One restoring step per cycle: subtract if it fits, shift remainder left.
    always_comb begin
        rem_d = rem_q;
        dvs_d = dvs_q;
        quo_d = quo_q;
        cnt_d = cnt_q;
        run_d = run_q;
        diff  = rem_q - {2'b00, dvs_q};
        if (start) begin
            rem_d = {3'b001, man_a};
            dvs_d = {1'b1, man_b};
            quo_d = '0;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            // remainder stays below 2*divisor, so bit 25 of diff is a clean sign
            if (!diff[25]) begin
                quo_d = {quo_q[23:0], 1'b1};
                rem_d = {diff[24:0], 1'b0};
            end else begin
                quo_d = {quo_q[23:0], 1'b0};
                rem_d = {rem_q[24:0], 1'b0};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd24) begin
                run_d = 1'b0;
                cnt_d = '0;
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/fp32_div.sv
// Sequential FP32 divider, round-toward-zero, 26-cycle fixed latency.
// FP_DIV_SPECIAL_EN enables inf/NaN/zero-divisor handling and exponent
// saturation; without it the exponent wraps modulo 256 like the multiplier.
module fp32_div
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] out,
    output logic        done,
    output logic        busy
);
    fsm_state_e         state_q, state_d;
    logic [31:0]        out_q, out_d;
    logic               done_q, done_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  eab_q, eab_d;     // ea - eb, bias added at normalize
    logic               az_q, az_d;
    logic               bz_q, bz_d;
`ifdef FP_DIV_SPECIAL_EN
    logic               ainf_q, ainf_d;  // either operand has exp field all ones
`endif

    logic               div_start, div_busy, div_done;
    logic [24:0]        quo;
    logic signed [9:0]  e;
    logic [MAN_W-1:0]   mout;
    logic [31:0]        res;

    assign out  = out_q;
    assign done = done_q;
    assign busy = (state_q != IDLE);

    mantissa_div u_mdiv (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .man_a (a[MAN_W-1:0]),
        .man_b (b[MAN_W-1:0]),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (quo)
    );

    // Normalize the quotient and apply zero/special handling.
    always_comb begin
        e    = eab_q + (quo[24] ? 10'sd127 : 10'sd126);
        mout = quo[24] ? quo[23:1] : quo[22:0];
        res  = {sign_q, e[7:0], mout};
`ifdef FP_DIV_SPECIAL_EN
        if (ainf_q || (az_q && bz_q))
            res = QNAN;
        else if (az_q)
            res = 32'h0;
        else if (bz_q || e > 10'sd254)
            res = {sign_q, EXP_MAX, 23'h0};
        else if (e < 10'sd1)
            res = {sign_q, 31'h0};
`else
        if (az_q || bz_q)
            res = 32'h0;
`endif
    end

    // Control FSM: capture operands, wait for the divider, register the result.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        done_d    = 1'b0;
        sign_d    = sign_q;
        eab_d     = eab_q;
        az_d      = az_q;
        bz_d      = bz_q;
`ifdef FP_DIV_SPECIAL_EN
        ainf_d    = ainf_q;
`endif
        div_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !div_busy) begin
                    sign_d    = a[31] ^ b[31];
                    eab_d     = $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]});
                    // denormals count as zero: only the exponent field matters
                    az_d      = (a[30:23] == 8'h00);
                    bz_d      = (b[30:23] == 8'h00);
`ifdef FP_DIV_SPECIAL_EN
                    ainf_d    = (a[30:23] == EXP_MAX) || (b[30:23] == EXP_MAX);
`endif
                    div_start = 1'b1;
                    state_d   = DIV;
                end
            end
            DIV: begin
                if (div_done) state_d = NORM;
            end
            NORM: begin
                out_d   = res;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Top-level state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            done_q  <= 1'b0;
            sign_q  <= 1'b0;
            eab_q   <= '0;
            az_q    <= 1'b0;
            bz_q    <= 1'b0;
`ifdef FP_DIV_SPECIAL_EN
            ainf_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            done_q  <= done_d;
            sign_q  <= sign_d;
            eab_q   <= eab_d;
            az_q    <= az_d;
            bz_q    <= bz_d;
`ifdef FP_DIV_SPECIAL_EN
            ainf_q  <= ainf_d;
`endif
        end
    end
endmodule
